apb_master: RTL and testbench

- APB initiator: converts single-beat commands from a simple valid/ready command port into APB3 setup/access transfers.
- Returns read data and error status on a valid/ready response port.
- It is the requester counterpart of the team's APB-slave peripherals (SPI, UART register files); used by the debug/command bridge and by block-level benches to drive peripheral registers.
- One outstanding transfer at a time; bounded wait on the completer's ready signal.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_wait_timer.sv | 33 +++
 rtl/apb_master.sv | 147 ++++++++++++++
 tb/tb_apb_master.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM states and response-flag bit positions,
// common to the initiator and the team's APB completers.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int RSP_ERR     = 0;
  localparam int RSP_TIMEOUT = 1;
  localparam int RSP_FLAGS_W = 2;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting for the completer; flags expiry on the
// cycle the count reaches TIMEOUT_CYCLE. TIMEOUT_CYCLE = 0 disables it.
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLE = 6
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  generate
    if (TIMEOUT_CYCLE == 0) begin : g_off
      logic w_unused;
      assign w_unused  = &{1'b0, i_clk, i_rst, i_clr, i_en};
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYCLE + 1);
      logic [CW-1:0] r_cnt;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                 r_cnt <= '0;
        else if (i_clr)                            r_cnt <= '0;
        else if (i_en && r_cnt != CW'(TIMEOUT_CYCLE)) r_cnt <= r_cnt + 1'b1;
      end

      // Fires on the waiting cycle that brings the count to the limit.
      assign o_expired = i_en && (r_cnt == CW'(TIMEOUT_CYCLE - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_master.sv
// APB3 initiator: one valid/ready command -> one SETUP/ACCESS transfer -> one
// response. Optional write strobes when APB_WSTRB_EN is defined.
module apb_master
  import apb_pkg::*;
#(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLE  = 6
) (
  input  logic                      apb_clk_in,
  input  logic                      apb_rst_in,
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic                      cmd_write_in,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_in,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata_in,
`ifdef APB_WSTRB_EN
  input  logic [APB_DATA_WIDTH/8-1:0] cmd_strb_in,
  output logic [APB_DATA_WIDTH/8-1:0] apb_strb_out,
`endif
  output logic                      rsp_valid_out,
  input  logic                      rsp_ready_in,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_out,
  output logic                      rsp_err_out,
  output logic                      rsp_timeout_out,
  output logic [APB_ADDR_WIDTH-1:0] apb_addr_out,
  output logic                      apb_psel_out,
  output logic                      apb_penable_out,
  output logic                      apb_write_out,
  output logic [APB_DATA_WIDTH-1:0] apb_wdata_out,
  input  logic [APB_DATA_WIDTH-1:0] apb_rdata_in,
  input  logic                      apb_ready_in,
  input  logic                      apb_slverr_in
);

  apb_state_e r_state, w_next;

  logic                      r_psel, r_penable, r_write, r_rsp_valid;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic [APB_DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [RSP_FLAGS_W-1:0]    r_flags;

  logic                      w_accept, w_expired, w_wait_en, w_wait_clr;
  logic                      w_psel_nxt, w_penable_nxt, w_rsp_valid_nxt, w_capture;
  logic [APB_DATA_WIDTH-1:0] w_rdata_nxt;
  logic [RSP_FLAGS_W-1:0]    w_flags_nxt;

  assign w_accept   = cmd_valid_in && (r_state == IDLE);
  assign w_wait_en  = (r_state == ACCESS) && !apb_ready_in;
  assign w_wait_clr = (r_state == SETUP);

  apb_wait_timer #(.TIMEOUT_CYCLE(TIMEOUT_CYCLE)) u_wait_timer (
    .i_clk     (apb_clk_in),
    .i_rst     (apb_rst_in),
    .i_clr     (w_wait_clr),
    .i_en      (w_wait_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cmd_valid_in) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (apb_ready_in || w_expired) w_next = RESP;
      RESP:    if (rsp_ready_in) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Next values for the registered outputs; ready beats an expiry on the same cycle.
  always_comb begin
    w_psel_nxt      = (w_next == SETUP) || (w_next == ACCESS);
    w_penable_nxt   = (w_next == ACCESS);
    w_rsp_valid_nxt = (w_next == RESP);
    w_capture       = 1'b0;
    w_rdata_nxt     = r_rdata;
    w_flags_nxt     = r_flags;
    if (r_state == ACCESS) begin
      if (apb_ready_in) begin
        w_capture            = 1'b1;
        w_rdata_nxt          = r_write ? '0 : apb_rdata_in;
        w_flags_nxt          = '0;
        w_flags_nxt[RSP_ERR] = apb_slverr_in;
      end else if (w_expired) begin
        w_capture                = 1'b1;
        w_rdata_nxt              = '0;
        w_flags_nxt[RSP_ERR]     = 1'b1;
        w_flags_nxt[RSP_TIMEOUT] = 1'b1;
      end
    end
  end

  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) begin
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_flags     <= '0;
    end else begin
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      if (w_accept) begin
        r_write <= cmd_write_in;
        r_addr  <= cmd_addr_in;
        r_wdata <= cmd_wdata_in;
      end
      if (w_capture) begin
        r_rdata <= w_rdata_nxt;
        r_flags <= w_flags_nxt;
      end
    end
  end

`ifdef APB_WSTRB_EN
  logic [APB_DATA_WIDTH/8-1:0] r_strb;

  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in)    r_strb <= '0;
    else if (w_accept) r_strb <= cmd_write_in ? cmd_strb_in : '0;
  end

  assign apb_strb_out = r_strb;
`endif

  assign cmd_ready_out   = (r_state == IDLE);
  assign rsp_valid_out   = r_rsp_valid;
  assign rsp_rdata_out   = r_rdata;
  assign rsp_err_out     = r_flags[RSP_ERR];
  assign rsp_timeout_out = r_flags[RSP_TIMEOUT];
  assign apb_addr_out    = r_addr;
  assign apb_psel_out    = r_psel;
  assign apb_penable_out = r_penable;
  assign apb_write_out   = r_write;
  assign apb_wdata_out   = r_wdata;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed plan steps plus randomized
// transfers checked against a transfer-level reference model.
module tb_apb_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_to;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] apb_addr;
  logic          apb_psel, apb_penable, apb_write;
  logic [DW-1:0] apb_wdata, apb_rdata;
  logic          apb_ready, apb_slverr;
`ifdef APB_WSTRB_EN
  logic [DW/8-1:0] cmd_strb, apb_strb;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  apb_master #(.APB_DATA_WIDTH(DW), .APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLE(TO)) dut (
    .apb_clk_in      (clk),
    .apb_rst_in      (rst),
    .cmd_valid_in    (cmd_valid),
    .cmd_ready_out   (cmd_ready),
    .cmd_write_in    (cmd_write),
    .cmd_addr_in     (cmd_addr),
    .cmd_wdata_in    (cmd_wdata),
`ifdef APB_WSTRB_EN
    .cmd_strb_in     (cmd_strb),
    .apb_strb_out    (apb_strb),
`endif
    .rsp_valid_out   (rsp_valid),
    .rsp_ready_in    (rsp_ready),
    .rsp_rdata_out   (rsp_rdata),
    .rsp_err_out     (rsp_err),
    .rsp_timeout_out (rsp_to),
    .apb_addr_out    (apb_addr),
    .apb_psel_out    (apb_psel),
    .apb_penable_out (apb_penable),
    .apb_write_out   (apb_write),
    .apb_wdata_out   (apb_wdata),
    .apb_rdata_in    (apb_rdata),
    .apb_ready_in    (apb_ready),
    .apb_slverr_in   (apb_slverr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One full transfer. The completer raises ready on ACCESS cycle waits+1;
  // the model expects an abort when that lies beyond TO cycles.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [DW-1:0] rd, input int waits, input logic slverr,
                      input int hold, input logic pend);
    logic          timed_out, e_err;
    logic [DW-1:0] e_rdata;
    int            exp_acc;
    timed_out = (TO > 0) && (waits + 1 > TO);
    exp_acc   = timed_out ? TO : waits + 1;
    e_rdata   = (timed_out || wr) ? '0 : rd;
    e_err     = timed_out ? 1'b1 : slverr;

    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_psel", {apb_psel, apb_penable}, 0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;

    @(negedge clk);
    chk("setup_sel_en", {apb_psel, apb_penable}, 2'b10);
    chk("setup_cmd_ready", cmd_ready, 0);
    chk("setup_addr", apb_addr, addr);
    chk("setup_write", apb_write, wr);
    chk("setup_wdata", apb_wdata, wdata);
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;

    for (int a = 1; a <= exp_acc; a++) begin
      @(negedge clk);
      chk("acc_sel_en", {apb_psel, apb_penable}, 2'b11);
      chk("acc_addr", apb_addr, addr);
      chk("acc_write", apb_write, wr);
      chk("acc_wdata", apb_wdata, wdata);
      chk("acc_no_rsp", rsp_valid, 0);
      apb_ready  = (a == waits + 1);
      apb_slverr = apb_ready ? slverr : 1'($urandom);
      apb_rdata  = apb_ready ? rd : $urandom;
    end

    @(negedge clk);
    apb_ready = 1'b0; apb_slverr = 1'b0;
    chk("resp_sel_en", {apb_psel, apb_penable}, 0);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_rdata", rsp_rdata, e_rdata);
    chk("resp_err", rsp_err, e_err);
    chk("resp_timeout", rsp_to, timed_out);
    chk("resp_cmd_ready", cmd_ready, 0);

    for (int h = 0; h < hold; h++) begin
      if (pend) begin cmd_valid = 1'b1; cmd_addr = $urandom; end
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rsp", {rsp_rdata, rsp_err, rsp_to}, {e_rdata, e_err, timed_out});
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_psel", apb_psel, 0);
    end

    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_valid", rsp_valid, 0);
    chk("done_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; apb_rdata = '0; apb_ready = 1'b0; apb_slverr = 1'b0;
`ifdef APB_WSTRB_EN
    cmd_strb = '1;
`endif
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_apb", {apb_psel, apb_penable, apb_write, apb_addr, apb_wdata}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_to, rsp_rdata}, 0);
    rst = 1'b0;

    xfer(1'b1, 32'hA030_0004, 32'h0000_005A, 32'h0, 0, 1'b0, 0, 1'b0);
    xfer(1'b0, 32'hA030_0010, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, 0, 1'b0);
    xfer(1'b0, 32'hA030_0014, 32'h0, 32'h1234_5678, 0, 1'b1, 0, 1'b0);
    xfer(1'b0, 32'hA030_0018, 32'h0, 32'hCAFE_F00D, 6, 1'b0, 0, 1'b0);
    xfer(1'b0, 32'hA030_001C, 32'h0, 32'hCAFE_F00D, 5, 1'b0, 0, 1'b0);
    xfer(1'b1, 32'hA030_0020, 32'hFFFF_0000, 32'h0, 7, 1'b1, 0, 1'b0);
    xfer(1'b0, 32'hA030_0024, 32'h0, 32'h0BAD_CAFE, 1, 1'b0, 5, 1'b1);
    xfer(1'b1, 32'hA030_0028, 32'h1111_2222, 32'h0, 0, 1'b0, 0, 1'b0);

    // Reset during the ACCESS wait: bus and response drop at once, no response later.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hA030_0030;
    @(negedge clk);
    cmd_valid = 1'b0; apb_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("prerst_sel_en", {apb_psel, apb_penable}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sel_en", {apb_psel, apb_penable}, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_quiet", {rsp_valid, apb_psel, apb_penable}, 0);
    end
    xfer(1'b0, 32'hA030_0034, 32'h0, 32'h5555_AAAA, 0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      xfer(1'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 8)),
           1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
